// File: rtl/amem_array.sv
// A-memory scratchpad array: 2**ADDR_WIDTH x DATA_WIDTH words with a zero-fill sweep after reset.
// Latency: read data is registered, one cycle after the arp strobe; a_valid pulses alongside it.
// Backpressure: none; arp/awp are ignored while the sweep runs and init_busy is high.
module amem_array #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] aadr,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic                  arp,
  input  logic                  awp,
  input  logic [DATA_WIDTH-1:0] l,
  output logic [DATA_WIDTH-1:0] a,
  output logic                  a_valid,
  output logic                  init_busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // The sweep and normal writes share one write port so the array maps onto a simple RAM.
  logic                    we;
  logic [ADDR_WIDTH-1:0]   wa;
  logic [DATA_WIDTH-1:0]   wd;
  logic                    rd;

  // State register; reset picks the sweep or goes straight to RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET ? CLEAR : RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and write-port steering: the sweep owns the port in CLEAR.
  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    we        = 1'b0;
    wa        = wadr;
    wd        = l;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        we        = 1'b1;
        wa        = idx;
        wd        = '0;
        if (idx == '1) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        we = awp;
      end
    endcase
  end

  assign rd = arp && (state == RUN);

  // Sweep index; advances once per CLEAR cycle and restarts from zero on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (state == CLEAR) begin
      idx <= idx + ADDR_WIDTH'(1);
    end
  end

  // Array write; contents are left alone while reset is held.
  always_ff @(posedge clk) begin
    if (reset_n && we) begin
      mem[wa] <= wd;
    end
  end

  // Registered read with write-first bypass when reading the address being written.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a       <= '0;
      a_valid <= 1'b0;
    end else begin
      a_valid <= rd;
      if (rd) begin
        a <= (awp && (aadr == wadr)) ? l : mem[aadr];
      end
    end
  end

endmodule

// File: tb/tb_amem_array.sv
// Bench for amem_array: scoreboard of expected read data checked whenever a_valid pulses.
// Two instances: default sweep-on-reset, and one with the sweep disabled.
// Sweep timing, ignored strobes and idle hold are checked directly from the stimulus thread.
module tb_amem_array;

  logic        clk;
  logic        reset_n, reset1_n;
  logic [9:0]  aadr, wadr, aadr1, wadr1;
  logic        arp, awp, arp1, awp1;
  logic [31:0] l, l1;
  logic [31:0] a, a1;
  logic        a_valid, a_valid1, init_busy, init_busy1;

  int passed;
  int total;
  logic [31:0] exp_q [$];
  logic [31:0] exp_q1 [$];

  amem_array #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .aadr(aadr), .wadr(wadr), .arp(arp), .awp(awp),
    .l(l), .a(a), .a_valid(a_valid), .init_busy(init_busy)
  );

  amem_array #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset_n(reset1_n), .aadr(aadr1), .wadr(wadr1), .arp(arp1), .awp(awp1),
    .l(l1), .a(a1), .a_valid(a_valid1), .init_busy(init_busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Monitors: pop and compare on every read response.
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL dut_unexpected_valid: got a=0x%08h expected no response", a);
      end else begin
        chk("dut_read", a, exp_q.pop_front());
      end
    end
    if (a_valid1 === 1'b1) begin
      if (exp_q1.size() == 0) begin
        total++;
        $display("FAIL dut1_unexpected_valid: got a=0x%08h expected no response", a1);
      end else begin
        chk("dut1_read", a1, exp_q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_a", a, 32'h0);
    chk("reset_a_valid", {31'b0, a_valid}, 32'h0);
    chk("reset_init_busy", {31'b0, init_busy}, 32'h1);
    reset_n = 1'b1;
  endtask

  // Counts cycles from reset release until init_busy falls, bounded.
  task automatic wait_sweep(input string name);
    int n;
    n = 0;
    while (init_busy && n < 2000) begin
      tick();
      n++;
    end
    chk(name, n, 1024);
  endtask

  task automatic op(input logic rd, input logic wr, input logic [9:0] ra, input logic [9:0] wa,
                    input logic [31:0] wd, input logic [31:0] exp);
    arp = rd; awp = wr; aadr = ra; wadr = wa; l = wd;
    if (rd) exp_q.push_back(exp);
    tick();
    arp = 1'b0; awp = 1'b0;
  endtask

  task automatic op1(input logic rd, input logic wr, input logic [9:0] ra, input logic [9:0] wa,
                     input logic [31:0] wd, input logic [31:0] exp);
    arp1 = rd; awp1 = wr; aadr1 = ra; wadr1 = wa; l1 = wd;
    if (rd) exp_q1.push_back(exp);
    tick();
    arp1 = 1'b0; awp1 = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    passed = 0; total = 0;
    reset_n = 1'b0; reset1_n = 1'b0;
    arp = 0; awp = 0; aadr = 0; wadr = 0; l = 0;
    arp1 = 0; awp1 = 0; aadr1 = 0; wadr1 = 0; l1 = 0;

    // Bring up, then plant data that the next sweep must erase.
    do_reset();
    wait_sweep("first_sweep_len");
    op(0, 1, 10'h000, 10'h3FF, 32'hDEADBEEF, 32'h0);
    op(1, 0, 10'h3FF, 10'h000, 32'h0, 32'hDEADBEEF);
    tick();

    // 1: sweep length and zeroed contents.
    do_reset();
    wait_sweep("sweep_len");
    op(1, 0, 10'h000, 10'h000, 32'h0, 32'h0);
    op(1, 0, 10'h1FF, 10'h000, 32'h0, 32'h0);
    op(1, 0, 10'h3FF, 10'h000, 32'h0, 32'h0);
    tick();

    // 2: write then read next cycle; then an idle cycle must hold a.
    op(0, 1, 10'h000, 10'h123, 32'hCAFEF00D, 32'h0);
    op(1, 0, 10'h123, 10'h000, 32'h0, 32'hCAFEF00D);
    tick();
    chk("idle_hold_a", a, 32'hCAFEF00D);
    chk("idle_a_valid", {31'b0, a_valid}, 32'h0);

    // 3: same-address read/write bypass.
    op(0, 1, 10'h000, 10'h055, 32'h00000001, 32'h0);
    op(1, 1, 10'h055, 10'h055, 32'h12345678, 32'h12345678);
    op(1, 0, 10'h055, 10'h000, 32'h0, 32'h12345678);

    // 4: read and write to different addresses in one cycle.
    op(0, 1, 10'h000, 10'h020, 32'h00000077, 32'h0);
    op(1, 1, 10'h020, 10'h010, 32'hAAAA5555, 32'h00000077);
    op(1, 0, 10'h010, 10'h000, 32'h0, 32'hAAAA5555);
    tick();

    // 5: strobes during the sweep are ignored.
    do_reset();
    n = 0;
    while (init_busy && n < 2000) begin
      if (n == 500) begin
        arp = 1; awp = 1; aadr = 10'h0AA; wadr = 10'h0AA; l = 32'hFFFFFFFF;
      end
      if (n == 503) begin
        arp = 0; awp = 0;
      end
      tick();
      n++;
      if (n > 500 && n <= 503) begin
        chk("sweep_a_zero", a, 32'h0);
        chk("sweep_no_valid", {31'b0, a_valid}, 32'h0);
      end
    end
    chk("sweep_len_strobed", n, 1024);
    op(1, 0, 10'h0AA, 10'h000, 32'h0, 32'h0);
    tick();

    // 6: reset mid-sweep restarts the full sweep.
    do_reset();
    repeat (600) tick();
    chk("mid_sweep_busy", {31'b0, init_busy}, 32'h1);
    do_reset();
    wait_sweep("restart_sweep_len");
    op(1, 0, 10'h123, 10'h000, 32'h0, 32'h0);
    tick();

    // No-sweep instance: ready immediately after reset.
    chk("nosweep_busy_in_reset", {31'b0, init_busy1}, 32'h0);
    reset1_n = 1'b1;
    chk("nosweep_busy", {31'b0, init_busy1}, 32'h0);
    op1(0, 1, 10'h000, 10'h2AB, 32'h0BADF00D, 32'h0);
    op1(1, 0, 10'h2AB, 10'h000, 32'h0, 32'h0BADF00D);
    op1(1, 1, 10'h011, 10'h011, 32'h5A5A5A5A, 32'h5A5A5A5A);
    chk("nosweep_busy_after", {31'b0, init_busy1}, 32'h0);

    repeat (3) tick();
    chk("dut_responses_outstanding", exp_q.size(), 0);
    chk("dut1_responses_outstanding", exp_q1.size(), 0);
    held = a;
    chk("final_a_hold", held, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/amem_array.md
Name: amem_array

Overview:
- A-memory storage array for the CADR datapath. It sits directly downstream of A-memory control and consumes its read/write address and strobe outputs.
- Holds 1024 x 32-bit scratchpad words. Provides a registered read port and a write port, with same-cycle write-to-read bypass.
- After reset it sweeps the whole array to zero before accepting traffic.

Parameters:
ADDR_WIDTH, 10, A-memory address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 32, A-memory word width.
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the sweep and enter RUN directly.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset_n  in  1  synchronous, active-low reset
aadr  in  ADDR_WIDTH  read address, equal to the write address during state_write
wadr  in  ADDR_WIDTH  latched write address
arp  in  1  read strobe (A read pulse)
awp  in  1  write strobe (A write pulse)
l  in  DATA_WIDTH  write data from the L register
a  out  DATA_WIDTH  registered read data
a_valid  out  1  one-cycle pulse: a was updated by a read this cycle
init_busy  out  1  high while the zero-fill sweep runs; strobes are ignored while high

Behaviour:
- Reset is sampled only at the clk edge. While reset_n=0:
  - a=0, a_valid=0, clear index=0.
  - state=CLEAR and init_busy=1 if CLEAR_ON_RESET=1; otherwise state=RUN and init_busy=0.
  - Array contents are not touched during reset itself.
- CLEAR state:
  - Each cycle: mem[idx] <= 0, then idx <= idx+1.
  - When idx = 2**ADDR_WIDTH-1 is written, next state=RUN.
  - The sweep takes exactly 1024 cycles after reset release. init_busy falls on the edge that enters RUN, so it is low in the 1025th cycle.
  - arp and awp are ignored: no array write, a holds 0, a_valid=0.
- Reset asserted mid-sweep restarts the sweep from idx 0.
- RUN state, write: if awp=1, mem[wadr] <= l at the edge.
- RUN state, read: if arp=1, a <= mem[aadr] at the edge and a_valid=1 for the following cycle. Read latency is 1 cycle.
- Bypass: if arp=1, awp=1 and aadr==wadr in the same cycle, a <= l (write-first), not the old contents.
- Idle read: if arp=0, a holds its previous value and a_valid=0.
- Simultaneous read and write to different addresses: both complete in the same cycle, independently.
- Write then read of the same address on the next cycle returns the new data. No hazard exists beyond the same-cycle case.
- Addresses use full ADDR_WIDTH decoding with no aliasing. Idx wrap-around is never used: the FSM leaves CLEAR before idx overflows.
- State encoding: CLEAR, RUN. RUN is terminal until reset.
- Array is inferable as a single-port-write, single-port-read synchronous RAM plus a bypass mux.

Test Plan:
1. Hold reset_n=0 for 3 cycles, then release -> init_busy=1 for 1024 cycles, 0 from cycle 1025. Reads of 0x000, 0x1FF and 0x3FF then return 0. Before running this scenario, write 0xDEADBEEF to 0x3FF in RUN, then reset, to prove the sweep overwrites prior contents.
2. In RUN: awp=1, wadr=0x123, l=0xCAFEF00D for one cycle; next cycle arp=1, aadr=0x123 -> one cycle later a=0xCAFEF00D and a_valid=1.
3. Same cycle: arp=1, awp=1, aadr=wadr=0x055, l=0x12345678, with old mem[0x055]=0x1 -> a=0x12345678 (bypass). A later read of 0x055 also returns 0x12345678.
4. Same cycle: write 0xAAAA5555 to 0x010 and read 0x020 (previously 0x77) -> a=0x77. A later read of 0x010 returns 0xAAAA5555.
5. Drive arp/awp with l=0xFFFFFFFF during the CLEAR sweep at cycle 500 -> a stays 0, a_valid stays 0. After RUN, read of the targeted address returns 0.
6. Assert reset_n=0 at sweep cycle 600, release -> sweep restarts, init_busy high for 1024 cycles. With CLEAR_ON_RESET=0 -> init_busy=0 immediately after reset, and a write/read pair works on the first post-reset cycles.
